fp_tanimoto_accum: RTL and testbench
====================================

// Module: fp_tanimoto_accum
// PURPOSE
// - Chemical-fingerprint similarity engine: holds 4 banks of query (Q) fingerprint words.
// - Streams a candidate fingerprint word per valid beat against all banks in parallel.
// - Per bank, accumulates popcount(Q&y) on lane A and popcount(Q|y) on lane B over element_length beats.
// - Stores per-element results in a result RAM for host readout.
// PARAMETERS
// NBANK  4   number of Q banks (= result banks); id width clog2(NBANK)=2
// AW     7   word/element address width (128 entries per bank)
// DW     16  fingerprint word width
// RW     32  accumulator/result width
// PORTS
// clk             in   1   single clock, all logic rising-edge
// rst             in   1   asynchronous, active-low reset (rst=0 resets)
// element_length  in   32  valid beats per element
// wren_q          in   1   Q RAM write enable
// wraddr_q        in   7   Q RAM write word address
// wrid_q          in   2   Q RAM write bank
// wrdin_q         in   16  Q RAM write data
// vld_in          in   1   candidate beat valid
// rdaddr_a        in   7   Q word address for lane A (AND)
// rdaddr_b        in   7   Q word address for lane B (OR)
// val_i_y_0       in   16  candidate fingerprint word
// rden_q          in   1   result read enable
// rdaddr_q        in   7   result element index
// rdid_q          in   2   result bank
// rddout_q_a_0    out  32  lane-A result (sum popcount AND)
// rddout_q_b_0    out  32  lane-B result (sum popcount OR)
// BEHAVIOUR
// - Reset: beat counter, element index, accumulators, pipeline valids, rddout_q_a_0/b_0 -> 0.
// - Reset does NOT clear Q RAM or result RAM; Q writes accepted even while rst=0.
// - Q write: when wren_q=1, Q[wrid_q][wraddr_q] <= wrdin_q at clock edge.
// - Same-cycle read of the written word returns old data (read-first).
// - Beat at edge t (vld_in=1):
//   - t+1: all 4 banks read Q[k][rdaddr_a] and Q[k][rdaddr_b]; y and valid are registered.
//   - t+2: acc_a[k] += popcount(Qa[k]&y); acc_b[k] += popcount(Qb[k]|y).
// - vld_in=0 beats are ignored entirely: no count, no accumulate; gaps are allowed anywhere.
// - Beat counter increments per accumulated beat. Element ends on beat count == element_length.
//   - element_length 0 is treated as 1.
//   - element_length is sampled at each beat.
// - End of element: the final sums (including the last beat) are written to
//   resA[k][elem_idx] and resB[k][elem_idx] for all k.
//   - Accumulators and beat counter then clear; elem_idx increments.
//   - Results are readable at most 4 cycles after the last beat's edge.
// - elem_idx wraps 127->0, overwriting old results; accumulators wrap mod 2^32.
// - Readout: when rden_q=1 at edge t, rddout_q_a_0/b_0 <= resA/resB[rdid_q][rdaddr_q], valid after t+1.
//   - Outputs hold their value while rden_q=0.
//   - A read of an entry in the same cycle it is written returns old data.
// - Reset mid-element: the partial element is discarded; elem_idx restarts at 0.
// STRUCTURE
// - Shared package fp_pkg: NBANK, AW, DW, RW, ID_W=2 constants and a popcount16 function.
// - One natural sub-module: fp_bank_lane. It is instantiated NBANK times and holds:
//   - Q RAM bank
//   - two read ports
//   - AND/OR popcount
//   - two accumulators
//   - result RAM slices
// - The top level holds the beat counter, element index, valid pipeline and readout mux.
// TESTING
// - Load Q (bank0: 1,2; bank1: 3,4; bank2: 5,6; bank3: 7,8 at words 0,1), pulse rst low.
//   -> Q contents survive the reset.
// - element_length=4, y=7, beats at addr 0,1,0,1 (a=b) -> element 0 results A/B:
//   bank0 4/12, bank1 6/12, bank2 8/12, bank3 6/14.
// - One idle cycle, then y=45, addr 0,1,0,1 -> element 1 results A/B:
//   bank0 2/18, bank1 4/18, bank2 6/18, bank3 6/18.
// - Readout, rden_q=1, sweep rdid 0..3 for rdaddr 0 then 1.
//   -> outputs match the values above 1 cycle later, then hold when rden_q drops.
// - Assert rst mid-element (2 of 4 beats), then run a full element.
//   -> it lands at elem_idx 0 with no partial-sum carryover.
// - element_length=1 with 130 beats -> elem_idx wraps; entry 0 holds beat 128 result.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared sizing constants and popcount helper for the Tanimoto fingerprint accumulator.
package fp_pkg;
  localparam int NBANK = 4;
  localparam int AW    = 7;
  localparam int DW    = 16;
  localparam int RW    = 32;
  localparam int ID_W  = 2;
  localparam int DEPTH = 1 << AW;
  localparam int PC_W  = 5;

  function automatic logic [PC_W-1:0] popcount16(input logic [DW-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DW; i++) begin
      c = c + {{(PC_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction
endpackage

// File: rtl/fp_bank_lane.sv
// One query bank: Q word RAM, AND/OR popcount lanes, running sums and per-element result RAM.
module fp_bank_lane
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          q_wren,
  input  logic [AW-1:0] q_wraddr,
  input  logic [DW-1:0] q_wrdin,
  input  logic [AW-1:0] rdaddr_a,
  input  logic [AW-1:0] rdaddr_b,
  input  logic          vld_p1,
  input  logic          last_p1,
  input  logic [DW-1:0] y_p1,
  input  logic [AW-1:0] elem_idx,
  input  logic [AW-1:0] res_rdaddr,
  output logic [RW-1:0] res_a,
  output logic [RW-1:0] res_b
);
  logic [DW-1:0] q_mem [DEPTH];
  logic [RW-1:0] res_a_mem [DEPTH];
  logic [RW-1:0] res_b_mem [DEPTH];

  logic [DW-1:0] qa_p1_q, qb_p1_q;
  logic [RW-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [RW-1:0] sum_a_p1, sum_b_p1;

  // p0 -> p1: Q write is read-first, so a same-edge read sees the old word
  always_ff @(posedge clk) begin
    if (q_wren) q_mem[q_wraddr] <= q_wrdin;
    qa_p1_q <= q_mem[rdaddr_a];
    qb_p1_q <= q_mem[rdaddr_b];
  end

  // p1 -> p2: accumulate; the closing beat's sum goes to the result RAM, not the accumulator
  always_comb begin
    sum_a_p1 = acc_a_q + RW'(popcount16(qa_p1_q & y_p1));
    sum_b_p1 = acc_b_q + RW'(popcount16(qb_p1_q | y_p1));
    acc_a_d  = acc_a_q;
    acc_b_d  = acc_b_q;
    if (vld_p1) begin
      acc_a_d = last_p1 ? '0 : sum_a_p1;
      acc_b_d = last_p1 ? '0 : sum_b_p1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_a_q <= '0;
      acc_b_q <= '0;
    end else begin
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1 && last_p1) begin
      res_a_mem[elem_idx] <= sum_a_p1;
      res_b_mem[elem_idx] <= sum_b_p1;
    end
  end

  assign res_a = res_a_mem[res_rdaddr];
  assign res_b = res_b_mem[res_rdaddr];
endmodule

// File: rtl/fp_tanimoto_accum.sv
// Tanimoto similarity engine top: beat counting, element indexing, valid pipeline and result readout.
module fp_tanimoto_accum
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   element_length,
  input  logic            wren_q,
  input  logic [AW-1:0]   wraddr_q,
  input  logic [ID_W-1:0] wrid_q,
  input  logic [DW-1:0]   wrdin_q,
  input  logic            vld_in,
  input  logic [AW-1:0]   rdaddr_a,
  input  logic [AW-1:0]   rdaddr_b,
  input  logic [DW-1:0]   val_i_y_0,
  input  logic            rden_q,
  input  logic [AW-1:0]   rdaddr_q,
  input  logic [ID_W-1:0] rdid_q,
  output logic [RW-1:0]   rddout_q_a_0,
  output logic [RW-1:0]   rddout_q_b_0
);
  logic            vld_p1_q, vld_p1_d;
  logic [DW-1:0]   y_p1_q, y_p1_d;
  logic [RW-1:0]   len_p1_q, len_p1_d;
  logic [RW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   elem_idx_q, elem_idx_d;
  logic            last_p1;
  logic [RW-1:0]   rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [RW-1:0]   lane_res_a [NBANK];
  logic [RW-1:0]   lane_res_b [NBANK];

  // p0 -> p1: capture beat; a zero length closes every beat
  always_comb begin
    vld_p1_d = vld_in;
    y_p1_d   = val_i_y_0;
    len_p1_d = (element_length == '0) ? RW'(1) : element_length;
  end

  always_ff @(posedge clk) begin
    y_p1_q   <= y_p1_d;
    len_p1_q <= len_p1_d;
  end

  // p1 -> p2: element bookkeeping shared by all banks
  always_comb begin
    last_p1    = vld_p1_q && ((cnt_q + RW'(1)) == len_p1_q);
    cnt_d      = cnt_q;
    elem_idx_d = elem_idx_q;
    if (vld_p1_q) begin
      cnt_d = last_p1 ? '0 : cnt_q + RW'(1);
      if (last_p1) elem_idx_d = elem_idx_q + AW'(1);
    end
  end

  always_comb begin
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (rden_q) begin
      rd_a_d = lane_res_a[rdid_q];
      rd_b_d = lane_res_b[rdid_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q   <= 1'b0;
      cnt_q      <= '0;
      elem_idx_q <= '0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      cnt_q      <= cnt_d;
      elem_idx_q <= elem_idx_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
    end
  end

  assign rddout_q_a_0 = rd_a_q;
  assign rddout_q_b_0 = rd_b_q;

  for (genvar k = 0; k < NBANK; k++) begin : g_bank
    fp_bank_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .q_wren     (wren_q && (wrid_q == ID_W'(k))),
      .q_wraddr   (wraddr_q),
      .q_wrdin    (wrdin_q),
      .rdaddr_a   (rdaddr_a),
      .rdaddr_b   (rdaddr_b),
      .vld_p1     (vld_p1_q),
      .last_p1    (last_p1),
      .y_p1       (y_p1_q),
      .elem_idx   (elem_idx_q),
      .res_rdaddr (rdaddr_q),
      .res_a      (lane_res_a[k]),
      .res_b      (lane_res_b[k])
    );
  end
endmodule

// File: tb/tb_fp_tanimoto_accum.sv
// Scoreboard bench for fp_tanimoto_accum: directed element runs, readout sweeps, reset and wrap cases.
`timescale 1ns/1ps
module tb_fp_tanimoto_accum;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] element_length;
  logic        wren_q;
  logic [6:0]  wraddr_q;
  logic [1:0]  wrid_q;
  logic [15:0] wrdin_q;
  logic        vld_in;
  logic [6:0]  rdaddr_a, rdaddr_b;
  logic [15:0] val_i_y_0;
  logic        rden_q;
  logic [6:0]  rdaddr_q;
  logic [1:0]  rdid_q;
  logic [31:0] rddout_q_a_0, rddout_q_b_0;

  fp_tanimoto_accum dut (
    .clk(clk), .rst(rst), .element_length(element_length),
    .wren_q(wren_q), .wraddr_q(wraddr_q), .wrid_q(wrid_q), .wrdin_q(wrdin_q),
    .vld_in(vld_in), .rdaddr_a(rdaddr_a), .rdaddr_b(rdaddr_b), .val_i_y_0(val_i_y_0),
    .rden_q(rden_q), .rdaddr_q(rdaddr_q), .rdid_q(rdid_q),
    .rddout_q_a_0(rddout_q_a_0), .rddout_q_b_0(rddout_q_b_0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic        rd_seen = 1'b0;
  logic [63:0] mon_e;

  logic [15:0] qv [4][2] = '{'{16'd1, 16'd2}, '{16'd3, 16'd4}, '{16'd5, 16'd6}, '{16'd7, 16'd8}};
  int unsigned el0_a [4] = '{4, 6, 8, 6};
  int unsigned el0_b [4] = '{12, 12, 12, 14};
  int unsigned el1_a [4] = '{2, 4, 6, 6};
  int unsigned el1_b [4] = '{18, 18, 18, 18};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read sampled at an edge presents data for the following half cycle
  always @(posedge clk) rd_seen <= rden_q;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got a=%0d b=%0d with no expected entry", rddout_q_a_0, rddout_q_b_0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_a", rddout_q_a_0, mon_e[63:32]);
        check("rd_b", rddout_q_b_0, mon_e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] y, input logic [6:0] a, input logic [6:0] b);
    vld_in = 1'b1; val_i_y_0 = y; rdaddr_a = a; rdaddr_b = b;
    tick();
    vld_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      vld_in = 1'b0; val_i_y_0 = 16'hffff; rdaddr_a = 7'h55; rdaddr_b = 7'h2a;
      tick();
    end
  endtask

  task automatic rd(input logic [1:0] id, input logic [6:0] addr, input logic [31:0] ea, input logic [31:0] eb);
    rden_q = 1'b1; rdid_q = id; rdaddr_q = addr;
    exp_q.push_back({ea, eb});
    tick();
    rden_q = 1'b0;
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b0;
    idle(n);
    rst = 1'b1;
    idle(1);
  endtask

  logic [15:0] wy [130];
  logic [6:0]  wa [130];
  logic [6:0]  wb [130];
  int          src;

  initial begin
    rst = 1'b0; element_length = 32'd4; wren_q = 1'b0; wraddr_q = '0; wrid_q = '0; wrdin_q = '0;
    vld_in = 1'b0; rdaddr_a = '0; rdaddr_b = '0; val_i_y_0 = '0; rden_q = 1'b0; rdaddr_q = '0; rdid_q = '0;
    idle(2);
    rst = 1'b1;
    idle(1);

    // Banks 0..2 loaded out of reset, bank 3 loaded while reset is held
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 2; w++) begin
        wren_q = 1'b1; wrid_q = 2'(k); wraddr_q = 7'(w); wrdin_q = qv[k][w];
        tick();
      end
    end
    wren_q = 1'b0;
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      wren_q = 1'b1; wrid_q = 2'd3; wraddr_q = 7'(w); wrdin_q = qv[3][w];
      tick();
    end
    wren_q = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(1);
    check("reset_rd_a", rddout_q_a_0, 32'd0);
    check("reset_rd_b", rddout_q_b_0, 32'd0);

    element_length = 32'd4;
    for (int i = 0; i < 4; i++) beat(16'd7, 7'(i % 2), 7'(i % 2));
    idle(1);
    for (int i = 0; i < 4; i++) beat(16'd45, 7'(i % 2), 7'(i % 2));
    idle(4);

    for (int k = 0; k < 4; k++) rd(2'(k), 7'd0, el0_a[k], el0_b[k]);
    for (int k = 0; k < 4; k++) rd(2'(k), 7'd1, el1_a[k], el1_b[k]);
    rdid_q = 2'd0; rdaddr_q = 7'd0;
    idle(1);
    check("hold_a_1", rddout_q_a_0, el1_a[3]);
    check("hold_b_1", rddout_q_b_0, el1_b[3]);
    idle(3);
    check("hold_a_4", rddout_q_a_0, el1_a[3]);
    check("hold_b_4", rddout_q_b_0, el1_b[3]);

    // Two of four beats, then reset: partial sums must vanish and indexing restarts
    beat(16'd7, 7'd0, 7'd0);
    beat(16'd7, 7'd1, 7'd1);
    rst = 1'b0;
    idle(1);
    check("midrst_rd_a", rddout_q_a_0, 32'd0);
    check("midrst_rd_b", rddout_q_b_0, 32'd0);
    rst = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) beat(16'd45, 7'(i % 2), 7'(i % 2));
    idle(4);
    for (int k = 0; k < 4; k++) rd(2'(k), 7'd0, el1_a[k], el1_b[k]);
    rd(2'd0, 7'd1, el1_a[0], el1_b[0]);
    idle(2);

    // Wrap: single-beat elements (length 0 counts as 1), 130 of them with gaps
    pulse_reset(2);
    for (int i = 0; i < 130; i++) begin
      wy[i] = 16'((i * 37 + 1) & 16'hffff);
      wa[i] = 7'(i % 2);
      wb[i] = 7'((i + 1) % 2);
      element_length = (i < 65) ? 32'd0 : 32'd1;
      if (i % 9 == 4) idle(1);
      beat(wy[i], wa[i], wb[i]);
    end
    idle(4);
    for (int e = 0; e < 3; e++) begin
      src = (e < 2) ? 128 + e : e;
      for (int k = 0; k < 4; k++) begin
        rd(2'(k), 7'(e),
           32'($countones(qv[k][wa[src][0]] & wy[src])),
           32'($countones(qv[k][wb[src][0]] | wy[src])));
      end
    end
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
